// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and every mux/ALU select code the datapath understands.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUC_ADD = 3'b000;
    localparam logic [2:0] ALUC_SUB = 3'b001;
    localparam logic [2:0] ALUC_AND = 3'b010;
    localparam logic [2:0] ALUC_OR  = 3'b011;
    localparam logic [2:0] ALUC_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:     imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus the instruction funct fields onto the
// ALU operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
) (
    input  logic [1:0]            aluop,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  op5,
    output logic [ALU_CTRL_W-1:0] alucontrol
);

    logic [2:0] ctrl;

    always_comb begin
        ctrl = ALUC_ADD;
        case (aluop)
            ALUOP_SUB: ctrl = ALUC_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can encode sub; addi ignores instr[30].
                    3'b000:  ctrl = (op5 && funct7) ? ALUC_SUB : ALUC_ADD;
                    3'b010:  ctrl = ALUC_SLT;
                    3'b110:  ctrl = ALUC_OR;
                    3'b111:  ctrl = ALUC_AND;
                    default: ctrl = ALUC_ADD;
                endcase
            end
            default: ctrl = ALUC_ADD;
        endcase
    end

    assign alucontrol = ALU_CTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM of the multi-cycle RV32I core: steps each instruction through
// fetch/decode/execute/writeback and drives every datapath enable and select.
module multicycle_control_unit
    import rv_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int SUPPORT_BNE = 1,
    parameter int MEM_WAIT_EN = 0,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            Opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  PCWrite,
    output logic                  AdrSrc,
    output logic                  MemWrite,
    output logic                  IRWrite,
    output logic [1:0]            ResultSrc,
    output logic [1:0]            ALUSrcA,
    output logic [1:0]            ALUSrcB,
    output logic [1:0]            ImmSrc,
    output logic [ALU_CTRL_W-1:0] ALUControl,
    output logic                  RegWrite,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instret,
    output logic [3:0]            state_o
);

    state_t     state;
    state_t     cur_state;
    state_t     next_state;
    logic       stall;
    logic       bne_sel;
    logic       retire;
    logic [1:0] aluop;
    logic       pcwrite_c;
    logic       irwrite_c;
    logic       regwrite_c;
    logic       memwrite_c;
    logic       illegal_c;

    assign stall   = (MEM_WAIT_EN != 0) && !mem_ready;
    assign bne_sel = (SUPPORT_BNE != 0) && funct3[0];

    // While reset is held the selects already show the FETCH pattern.
    assign cur_state = reset ? S_FETCH : state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        retire     = 1'b0;
        aluop      = ALUOP_ADD;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        pcwrite_c  = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        memwrite_c = 1'b0;
        illegal_c  = 1'b0;
        case (cur_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                irwrite_c  = !stall;
                pcwrite_c  = !stall;
                next_state = stall ? S_FETCH : S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Opcode)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_RTYPE:     next_state = S_EXECUTER;
                    OP_ITYPE:     next_state = S_EXECUTEI;
                    OP_BRANCH:    next_state = S_BRANCH;
                    OP_JAL:       next_state = S_JAL;
                    default: begin
                        next_state = S_FETCH;
                        illegal_c  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                next_state = Opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc     = 1'b1;
                next_state = stall ? S_MEMREAD : S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                regwrite_c = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWRITE: begin
                // Strobe stays up across wait states; memory takes it once ready.
                AdrSrc     = 1'b1;
                memwrite_c = 1'b1;
                retire     = !stall;
                next_state = stall ? S_MEMWRITE : S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                aluop      = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RD1;
                aluop     = ALUOP_SUB;
                pcwrite_c = zero ^ bne_sel;
                retire    = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pcwrite_c  = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    assign PCWrite  = pcwrite_c && !reset;
    assign IRWrite  = irwrite_c && !reset;
    assign RegWrite = regwrite_c && !reset;
    assign MemWrite = memwrite_c && !reset;
    assign illegal  = illegal_c && !reset;
    assign ImmSrc   = imm_src(Opcode);
    assign state_o  = state;

    alu_decoder #(
        .ALU_CTRL_W(ALU_CTRL_W)
    ) u_alu_decoder (
        .aluop     (aluop),
        .funct3    (funct3),
        .funct7    (funct7),
        .op5       (Opcode[5]),
        .alucontrol(ALUControl)
    );

endmodule
